muldiv_arbiter: RTL and testbench
=================================

// Module: muldiv_arbiter
// PURPOSE
//  Shares one iterative multiply/divide core between two requesters (r0: processor PIO side,
//  r1: UART command path). Round-robin arbitration, operand latching, core start/done
//  sequencing, divide-by-zero and timeout handling, result return with per-requester done pulse.
//  Sits between the PIO/UART front ends and the core producing produto/quociente/resto.
// PARAMETERS
//  W            32   operand/result width
//  TIMEOUT_CYC  255  max WAIT cycles before abort (>=1)
// PORTS
//  clk_clk        in   1  single system clock
//  reset_reset    in   1  reset, asynchronous, active-high
//  r0_req,r1_req  in   1  request; held high until matching done
//  r0_op,r1_op    in   2  00 MUL, 01 DIV, 10/11 reserved
//  r0_a,r1_a      in   W  operand A (multiplicand/dividend)
//  r0_b,r1_b      in   W  operand B (multiplier/divisor)
//  r0_done,r1_done out 1  one-cycle pulse: res_* valid for that requester
//  res_produto    out  W  product (low W bits)
//  res_quociente  out  W  quotient
//  res_resto      out  W  remainder
//  res_err        out  1  1 = div-by-zero, reserved op or timeout
//  busy           out  1  high in any state except IDLE
//  core_start     out  1  one-cycle start pulse to core
//  core_op        out  2  latched op
//  core_a,core_b  out  W  latched operands, stable from ISSUE through WAIT
//  core_done      in   1  core completion (pulse or level, first high cycle in WAIT used)
//  core_produto,core_quociente,core_resto in W  core results, valid with core_done
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=r1 (so r0 wins first tie), timer 0.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE; registered outputs.
//  IDLE: reqs sampled only here. None -> stay. One -> grant it. Both -> grant the one not in
//   last_grant. Latch op/a/b of grantee. Reserved op, or DIV with b==0 -> RESP with error;
//   else -> ISSUE.
//  ISSUE: core_start=1 exactly this cycle; timer cleared; -> WAIT.
//  WAIT: core_done=1 -> latch core results, res_err=0, -> RESP. Else timer++; timer reaches
//   TIMEOUT_CYC -> res_err=1, results 0, -> RESP. core_done in ISSUE cycle ignored.
//  RESP: granted rX_done=1 for one cycle; last_grant<=grantee; -> IDLE. res_* and res_err hold
//   until next RESP (stable for software readback).
//  Div-by-zero: res_quociente=all-ones, res_resto=a, res_produto=0, res_err=1; core not started.
//  Reserved op: all results 0, res_err=1; core not started.
//  MUL fills res_produto only (quociente/resto 0); DIV fills quociente/resto (produto 0).
//  Latency (req high in IDLE cycle 0): ISSUE cycle 1, core_done in cycle n>=2 -> done in n+1.
//   Error-in-IDLE path: done in cycle 1.
//  Requester drops req mid-operation: operation completes, done still pulses, no abort.
//  Request re-asserted right after done: earliest re-grant is the IDLE cycle after RESP;
//   with both pending, strict alternation.
//  Reset mid-operation: immediate return to reset values; core_start low; no done pulse.
// STRUCTURE
//  Package muldiv_pkg: op codes OP_MUL/OP_DIV, state enum (IDLE,ISSUE,WAIT,RESP),
//   default W, width of timer derived from TIMEOUT_CYC.
//  Sub-module rr_arb2: 2-way round-robin (req[1:0], last_grant -> grant[1:0], one-hot or 0).
//  Top: FSM, operand/result registers, timeout counter, error generation.
// TESTING
//  Core model: fixed latency 8 cycles, optional stuck-low mode.
//  1 r0 MUL a=7 b=6 -> core_start one pulse, r0_done one pulse 10 cycles after req, produto=42, err=0.
//  2 r1 DIV a=100 b=7 -> quociente=14, resto=2, produto=0, r1_done only, err=0.
//  3 r0 DIV a=100 b=0 -> no core_start, r0_done cycle 1, quociente=FFFFFFFF, resto=100, err=1.
//  4 r0,r1 both req from reset (MUL 3*5, DIV 9/2) -> r0 served first (15), then r1 (q4 r1); repeat
//    both held -> grants alternate r0,r1,r0.
//  5 core stuck low, r1 MUL -> r1_done exactly TIMEOUT_CYC+2 cycles after req, err=1, results 0,
//    busy low next cycle.
//  6 reset_reset pulsed during WAIT -> all outputs 0 same cycle, no done, next req served normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div arbiter.
// Op codes, FSM states and timer width helper.
package muldiv_pkg;

  localparam int W_DEF = 32;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic int tmr_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/muldiv_arbiter_if.sv
// Requester, result and core-side signals of the arbiter.
// slave = arbiter view, master = front ends plus core.
interface muldiv_arbiter_if #(
  parameter int W = 32
);

  logic         r0_req;
  logic         r1_req;
  logic [1:0]   r0_op;
  logic [1:0]   r1_op;
  logic [W-1:0] r0_a;
  logic [W-1:0] r1_a;
  logic [W-1:0] r0_b;
  logic [W-1:0] r1_b;

  logic         r0_done;
  logic         r1_done;
  logic [W-1:0] res_produto;
  logic [W-1:0] res_quociente;
  logic [W-1:0] res_resto;
  logic         res_err;
  logic         busy;

  logic         core_start;
  logic [1:0]   core_op;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_done;
  logic [W-1:0] core_produto;
  logic [W-1:0] core_quociente;
  logic [W-1:0] core_resto;

  modport slave (
    input  r0_req, r1_req,
    input  r0_op, r1_op,
    input  r0_a, r1_a, r0_b, r1_b,
    output r0_done, r1_done,
    output res_produto, res_quociente,
    output res_resto, res_err, busy,
    output core_start, core_op,
    output core_a, core_b,
    input  core_done, core_produto,
    input  core_quociente, core_resto
  );

  modport master (
    output r0_req, r1_req,
    output r0_op, r1_op,
    output r0_a, r1_a, r0_b, r1_b,
    input  r0_done, r1_done,
    input  res_produto, res_quociente,
    input  res_resto, res_err, busy,
    input  core_start, core_op,
    input  core_a, core_b,
    output core_done, core_produto,
    output core_quociente, core_resto
  );

endinterface

// File: rtl/muldiv_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// On a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative mul/div core between two requesters.
// Handles grant, operand latch, core sequencing, errors and timeout.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_clk,
  input  logic reset_reset,
  muldiv_arbiter_if.slave bus
);

  localparam int TW = tmr_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         gnt_q, gnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;
  logic         d0_q, d0_d;
  logic         d1_q, d1_d;
  logic [W-1:0] prod_q, prod_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic         err_q, err_d;
  logic [1:0]   grant;

  rr_arb2 u_arb (
    .req        ({bus.r1_req, bus.r0_req}),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    tmr_d   = tmr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    d0_d    = 1'b0;
    d1_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          gnt_d = grant[1];
          op_d  = grant[1] ? bus.r1_op : bus.r0_op;
          a_d   = grant[1] ? bus.r1_a  : bus.r0_a;
          b_d   = grant[1] ? bus.r1_b  : bus.r0_b;
          if (op_d == OP_DIV && b_d == '0) begin
            prod_d  = '0;
            quo_d   = '1;
            rem_d   = a_d;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (op_d != OP_MUL &&
                       op_d != OP_DIV) begin
            prod_d  = '0;
            quo_d   = '0;
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (op_q == OP_MUL) begin
            prod_d = bus.core_produto;
            quo_d  = '0;
            rem_d  = '0;
          end else begin
            prod_d = '0;
            quo_d  = bus.core_quociente;
            rem_d  = bus.core_resto;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_d == TMAX) begin
            prod_d  = '0;
            quo_d   = '0;
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // done pulses on the cycle the FSM sits in RESP
    if (state_d == RESP && state_q != RESP) begin
      d0_d = ~gnt_d;
      d1_d = gnt_d;
    end
    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      tmr_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign bus.r0_done       = d0_q;
  assign bus.r1_done       = d1_q;
  assign bus.res_produto   = prod_q;
  assign bus.res_quociente = quo_q;
  assign bus.res_resto     = rem_q;
  assign bus.res_err       = err_q;
  assign bus.busy          = busy_q;
  assign bus.core_start    = start_q;
  assign bus.core_op       = op_q;
  assign bus.core_a        = a_q;
  assign bus.core_b        = b_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench for muldiv_arbiter with an 8-cycle core model.
// Stimulus queues expectations; a negedge monitor checks each done.
module tb_muldiv_arbiter;

  localparam int TO = 255;

  typedef struct {
    int          cyc;
    logic [31:0] p;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  int   cyc = 0;
  int   cdn = 0;
  int   starts = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic pd0 = 1'b0;
  logic pd1 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  muldiv_arbiter_if #(.W(32)) bus ();

  muldiv_arbiter #(.W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) cdn <= 0;
    else if (bus.core_start) cdn <= 8;
    else if (cdn != 0) cdn <= cdn - 1;
  end

  assign bus.core_done = (cdn == 1) && !stuck;
  assign bus.core_produto = bus.core_a * bus.core_b;
  assign bus.core_quociente =
    (bus.core_b != 0) ? bus.core_a / bus.core_b : '0;
  assign bus.core_resto =
    (bus.core_b != 0) ? bus.core_a % bus.core_b : '0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cmp(input string nm, input exp_t e);
    check({nm, "_cyc"}, 32'(cyc), 32'(e.cyc));
    check({nm, "_prod"}, bus.res_produto, e.p);
    check({nm, "_quo"}, bus.res_quociente, e.q);
    check({nm, "_rem"}, bus.res_resto, e.r);
    check({nm, "_err"}, 32'(bus.res_err), 32'(e.e));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.core_start) starts <= starts + 1;
    if (bus.r0_done || bus.r1_done)
      check("done_onehot", 32'(bus.r0_done & bus.r1_done), 0);
    if (bus.r0_done) begin
      check("r0_pulse", 32'(pd0), 0);
      check("r0_pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        cmp("r0", e);
      end
    end
    if (bus.r1_done) begin
      check("r1_pulse", 32'(pd1), 0);
      check("r1_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        cmp("r1", e);
      end
    end
    pd0 <= bus.r0_done;
    pd1 <= bus.r1_done;
  end

  task automatic drive(input bit r, input logic rq,
                       input logic [1:0] op,
                       input logic [31:0] a, b);
    if (r) begin
      bus.r1_req = rq; bus.r1_op = op;
      bus.r1_a = a;    bus.r1_b = b;
    end else begin
      bus.r0_req = rq; bus.r0_op = op;
      bus.r0_a = a;    bus.r0_b = b;
    end
  endtask

  task automatic push(input bit r, input int c,
                      input logic [31:0] p, q, rm,
                      input logic e);
    exp_t x;
    x.cyc = c; x.p = p; x.q = q; x.r = rm; x.e = e;
    if (r) q1.push_back(x);
    else q0.push_back(x);
  endtask

  task automatic wait_done(input bit r, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (r ? bus.r1_done : bus.r0_done) break;
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      $display("FAIL timeout_r%0d: no done in %0d cycles",
               r, budget);
    end
  endtask

  task automatic run1(input string nm, input bit r,
                      input logic [1:0] op,
                      input logic [31:0] a, b, p, q, rm,
                      input logic e, input int lat,
                      input int nst);
    int s0 = starts;
    drive(r, 1'b1, op, a, b);
    push(r, cyc + lat, p, q, rm, e);
    wait_done(r, lat + 20);
    drive(r, 1'b0, 2'b00, 0, 0);
    @(posedge clk); #1;
    check({nm, "_starts"}, 32'(starts - s0), 32'(nst));
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_r0d"}, 32'(bus.r0_done), 0);
    check({nm, "_r1d"}, 32'(bus.r1_done), 0);
    check({nm, "_busy"}, 32'(bus.busy), 0);
    check({nm, "_start"}, 32'(bus.core_start), 0);
    check({nm, "_op"}, 32'(bus.core_op), 0);
    check({nm, "_a"}, bus.core_a, 0);
    check({nm, "_b"}, bus.core_b, 0);
    check({nm, "_prod"}, bus.res_produto, 0);
    check({nm, "_quo"}, bus.res_quociente, 0);
    check({nm, "_rem"}, bus.res_resto, 0);
    check({nm, "_err"}, 32'(bus.res_err), 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    drive(0, 1'b0, 2'b00, 0, 0);
    drive(1, 1'b0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    run1("t1", 0, 2'b00, 7, 6, 42, 0, 0, 1'b0, 10, 1);
    run1("t2", 1, 2'b01, 100, 7, 0, 14, 2, 1'b0, 10, 1);
    run1("t3", 0, 2'b01, 100, 0, 0, 32'hFFFF_FFFF,
         100, 1'b1, 1, 0);
    run1("rsv", 1, 2'b10, 5, 6, 0, 0, 0, 1'b1, 1, 0);

    pulse_rst();
    drive(0, 1'b1, 2'b00, 3, 5);
    drive(1, 1'b1, 2'b01, 9, 2);
    s = cyc;
    push(0, s + 10, 15, 0, 0, 1'b0);
    push(1, s + 21, 0, 4, 1, 1'b0);
    wait_done(0, 30);
    drive(0, 1'b1, 2'b00, 4, 4);
    push(0, s + 32, 16, 0, 0, 1'b0);
    wait_done(1, 30);
    drive(1, 1'b1, 2'b01, 50, 7);
    push(1, s + 43, 0, 7, 1, 1'b0);
    wait_done(0, 30);
    drive(0, 1'b0, 2'b00, 0, 0);
    wait_done(1, 30);
    drive(1, 1'b0, 2'b00, 0, 0);
    @(posedge clk); #1;

    stuck = 1'b1;
    run1("t5", 1, 2'b00, 3, 4, 0, 0, 0, 1'b1, TO + 2, 1);
    check("t5_busy", 32'(bus.busy), 0);
    stuck = 1'b0;

    drive(0, 1'b1, 2'b00, 9, 9);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t6");
    drive(0, 1'b0, 2'b00, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run1("t6b", 0, 2'b00, 2, 3, 6, 0, 0, 1'b0, 10, 1);

    repeat (3) @(posedge clk);
    #1;
    check("q_empty", 32'(q0.size() + q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
